// File: rtl/alu_top.sv
// SPI-attached 8-bit ALU: receives {a,b,opcode} LSB first and returns {flags,result} of frame N during frame N+1.
// Result is loaded three clk after synchronized ss rises; the SPI master is never stalled, so there is no backpressure.
module alu_top #(
  parameter int FRAME_SIZE = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ss,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic rvalid
);

  localparam int TX_W  = 20;
  localparam int CNT_W = $clog2(FRAME_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_SIZE);

  typedef enum logic [1:0] {IDLE, RECV, EXEC, LOAD} state_t;

  state_t                  state_q, state_d;
  logic                    ss_q1, ss_q2, ss_q3;
  logic                    sclk_q1, sclk_q2, sclk_q3;
  logic                    mosi_q1, mosi_q2;
  logic [FRAME_SIZE-1:0]   rx_q, rx_d;
  logic [TX_W-1:0]         tx_q, tx_d;
  logic [TX_W-1:0]         res_q, res_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic ss_fall, ss_rise, sclk_rise;

  assign ss_fall   = ss_q3 & ~ss_q2;
  assign ss_rise   = ~ss_q3 & ss_q2;
  assign sclk_rise = ~sclk_q3 & sclk_q2;

  // ALU operands decoded straight from the receive register
  logic [7:0]  op_a, op_b;
  logic [3:0]  opcode;
  logic [2:0]  shamt;
  logic [8:0]  sum9, inc9;
  logic [7:0]  diff8;
  logic [15:0] diff16, rotl16, rotr16, alu_res;
  logic        alu_carry, alu_ovf, alu_neg, alu_zero;

  assign op_a   = rx_q[19:12];
  assign op_b   = rx_q[11:4];
  assign opcode = rx_q[3:0];
  assign shamt  = op_b[2:0];

  always_comb begin
    sum9      = {1'b0, op_a} + {1'b0, op_b};
    inc9      = {1'b0, op_a} + 9'd1;
    diff8     = op_a - op_b;
    diff16    = {8'h00, op_a} - {8'h00, op_b};
    rotl16    = {op_a, op_a} << shamt;
    rotr16    = {op_a, op_a} >> shamt;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (opcode)
      4'h0: begin
        alu_res   = {7'h00, sum9};
        alu_carry = sum9[8];
        alu_ovf   = (op_a[7] == op_b[7]) && (sum9[7] != op_a[7]);
      end
      4'h1: begin
        alu_res   = diff16;
        alu_carry = (op_a < op_b);
        alu_ovf   = (op_a[7] != op_b[7]) && (diff8[7] != op_a[7]);
      end
      4'h2: alu_res = {8'h00, op_a} * {8'h00, op_b};
      4'h3: alu_res = {8'h00, op_a & op_b};
      4'h4: alu_res = {8'h00, op_a | op_b};
      4'h5: alu_res = {8'h00, op_a ^ op_b};
      4'h6: alu_res = {8'h00, ~op_a};
      4'h7: alu_res = {8'h00, ~(op_a & op_b)};
      4'h8: alu_res = {8'h00, ~(op_a | op_b)};
      4'h9: alu_res = {8'h00, ~(op_a ^ op_b)};
      4'hA: alu_res = {8'h00, op_a << shamt};
      4'hB: alu_res = {8'h00, op_a >> shamt};
      4'hC: alu_res = {8'h00, rotl16[15:8]};
      4'hD: alu_res = {8'h00, rotr16[7:0]};
      4'hE: begin
        alu_res   = {7'h00, inc9};
        alu_carry = inc9[8];
      end
      default: alu_res = {8'h00, op_a - 8'd1};
    endcase
    alu_neg  = (opcode == 4'h1 || opcode == 4'h2) ? alu_res[15] : alu_res[7];
    alu_zero = (alu_res == 16'h0000);
  end

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (sclk_rise && !ss_q2) begin
          tx_d = {1'b0, tx_q[TX_W-1:1]};
          if (cnt_q != FULL_CNT) begin
            rx_d  = {mosi_q2, rx_q[FRAME_SIZE-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (ss_rise) begin
          if (cnt_q == FULL_CNT) begin
            state_d = EXEC;
          end else begin
            // Short frame: undo the shifting so the last result is offered again
            state_d = IDLE;
            tx_d    = res_q;
          end
        end
      end
      EXEC: begin
        res_d   = {alu_ovf, alu_neg, alu_carry, alu_zero, alu_res};
        state_d = LOAD;
      end
      default: begin
        tx_d    = res_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ss_q1   <= 1'b0;
      ss_q2   <= 1'b0;
      ss_q3   <= 1'b0;
      sclk_q1 <= 1'b0;
      sclk_q2 <= 1'b0;
      sclk_q3 <= 1'b0;
      mosi_q1 <= 1'b0;
      mosi_q2 <= 1'b0;
      rx_q    <= '0;
      tx_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ss_q1   <= ss;
      ss_q2   <= ss_q1;
      ss_q3   <= ss_q2;
      sclk_q1 <= sclk;
      sclk_q2 <= sclk_q1;
      sclk_q3 <= sclk_q2;
      mosi_q1 <= mosi;
      mosi_q2 <= mosi_q1;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign miso   = tx_q[0];
  assign busy   = (state_q != IDLE);
  assign rvalid = (state_q == LOAD);

endmodule

// File: tb/tb_alu_top.sv
// Directed bench for alu_top: SPI frames with hand-computed returned words.
module tb_alu_top;

  logic clk = 1'b0;
  logic reset_n;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;
  logic busy;
  logic rvalid;

  int   checks = 0;
  int   errors = 0;
  logic busy_mid;

  alu_top #(.FRAME_SIZE(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ss      (ss),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .busy    (busy),
    .rvalid  (rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    return {a, b, op};
  endfunction

  task automatic shift_bits(input logic [19:0] f, input int nbits, output logic [19:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = f[i];
      repeat (2) @(negedge clk);
      sclk   = 1'b1;
      got[i] = miso;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [19:0] f, input int nbits, output logic [19:0] got, output int pulses);
    @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
    shift_bits(f, nbits, got);
    repeat (2) @(negedge clk);
    busy_mid = busy;
    ss       = 1'b1;
    pulses   = 0;
    repeat (12) begin
      @(negedge clk);
      if (rvalid === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ss      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({miso, busy, rvalid} !== 3'b000) begin errors++; $display("FAIL reset_held miso/busy/rvalid=%b exp=000", {miso, busy, rvalid}); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
  endtask

  task automatic test_add_twice();
    logic [19:0] got;
    int          p;
    xfer(mk(8'h00, 8'h01, 4'h0), 20, got, p);
    checks++; if (got !== 20'h00000) begin errors++; $display("FAIL add1_ret got=%h exp=%h", got, 20'h00000); end
    checks++; if (p !== 1) begin errors++; $display("FAIL add1_rvalid pulses=%0d exp=1", p); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL add1_busy_mid got=%b exp=1", busy_mid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add1_busy_after got=%b exp=0", busy); end
    xfer(mk(8'h00, 8'h01, 4'h0), 20, got, p);
    checks++; if (got !== 20'h00001) begin errors++; $display("FAIL add2_ret got=%h exp=%h", got, 20'h00001); end
    checks++; if (p !== 1) begin errors++; $display("FAIL add2_rvalid pulses=%0d exp=1", p); end
  endtask

  task automatic test_add_carry();
    logic [19:0] got;
    int          p;
    xfer(mk(8'hFF, 8'h01, 4'h0), 20, got, p);
    checks++; if (got !== 20'h00001) begin errors++; $display("FAIL addc_prev got=%h exp=%h", got, 20'h00001); end
    xfer(mk(8'h05, 8'h07, 4'h1), 20, got, p);
    checks++; if (got !== 20'h20100) begin errors++; $display("FAIL add_carry got=%h exp=%h", got, 20'h20100); end
  endtask

  task automatic test_sub();
    logic [19:0] got;
    int          p;
    xfer(mk(8'hFF, 8'hFF, 4'h2), 20, got, p);
    checks++; if (got !== 20'h6FFFE) begin errors++; $display("FAIL sub_borrow got=%h exp=%h", got, 20'h6FFFE); end
    checks++; if (p !== 1) begin errors++; $display("FAIL sub_rvalid pulses=%0d exp=1", p); end
  endtask

  task automatic test_abort_then_mul();
    logic [19:0] got;
    int          p;
    xfer(mk(8'h12, 8'h34, 4'h5), 10, got, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL abort_rvalid pulses=%0d exp=0", p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (got[9:0] !== 10'h201) begin errors++; $display("FAIL abort_partial got=%h exp=%h", got[9:0], 10'h201); end
    xfer(mk(8'h7F, 8'h01, 4'h0), 20, got, p);
    checks++; if (got !== 20'h4FE01) begin errors++; $display("FAIL mul_after_abort got=%h exp=%h", got, 20'h4FE01); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] frm [8];
    logic [19:0] exp [8];
    logic [19:0] got;
    int          p;
    frm[0] = mk(8'h80, 8'h01, 4'h1); exp[0] = 20'hC0080;
    frm[1] = mk(8'hF0, 8'h3C, 4'h5); exp[1] = 20'h8007F;
    frm[2] = mk(8'h81, 8'h01, 4'hC); exp[2] = 20'h400CC;
    frm[3] = mk(8'hFF, 8'h00, 4'hE); exp[3] = 20'h00003;
    frm[4] = mk(8'h00, 8'h00, 4'hF); exp[4] = 20'h20100;
    frm[5] = mk(8'hF0, 8'h0F, 4'h3); exp[5] = 20'h400FF;
    frm[6] = mk(8'h80, 8'h0F, 4'hB); exp[6] = 20'h10000;
    frm[7] = mk(8'h00, 8'h00, 4'h0); exp[7] = 20'h00001;
    for (int i = 0; i < 8; i++) begin
      xfer(frm[i], 20, got, p);
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp[i]); end
      checks++; if (p !== 1) begin errors++; $display("FAIL b2b_rvalid_%0d pulses=%0d exp=1", i, p); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [19:0] got;
    int          p;
    @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
    shift_bits(mk(8'h01, 8'h01, 4'h0), 10, got);
    reset_n = 1'b0;
    p = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid === 1'b1) p++;
    end
    checks++; if ({miso, busy} !== 2'b00) begin errors++; $display("FAIL midrst_outputs miso/busy=%b exp=00", {miso, busy}); end
    ss = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rvalid === 1'b1) p++;
    end
    checks++; if (p !== 0) begin errors++; $display("FAIL midrst_rvalid pulses=%0d exp=0", p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    xfer(mk(8'h00, 8'h00, 4'h0), 20, got, p);
    checks++; if (got !== 20'h00000) begin errors++; $display("FAIL midrst_ret got=%h exp=%h", got, 20'h00000); end
    checks++; if (p !== 1) begin errors++; $display("FAIL midrst_next_rvalid pulses=%0d exp=1", p); end
  endtask

  initial begin
    test_reset();
    test_add_twice();
    test_add_carry();
    test_sub();
    test_abort_then_mul();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
